// File: rtl/udma_stream_sink_if.sv
// Stream bus carrying beats from a uDMA stream source to a stream sink.
// The master modport drives the beat; the slave modport returns ready.
interface udma_stream_sink_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int STREAM_ID_WIDTH = 2
);
  logic [STREAM_ID_WIDTH-1:0] dest;
  logic [DATA_WIDTH-1:0]      data;
  logic [1:0]                 datasize;
  logic                       valid;
  logic                       sot;
  logic                       eot;
  logic                       ready;

  modport master (
    output dest, data, datasize, valid, sot, eot,
    input  ready
  );

  modport slave (
    input  dest, data, datasize, valid, sot, eot,
    output ready
  );
endinterface

// File: rtl/udma_stream_sink.sv
// Stream sink: buffers beats addressed to INST_ID and writes them into an L2
// circular buffer over an RX-channel request/grant port, reporting each write.
module udma_stream_sink #(
  parameter int L2_AWIDTH_NOAL  = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int STREAM_ID_WIDTH = 2,
  parameter int INST_ID         = 0,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cfg_en_i,
  input  logic                       cfg_clr_i,
  input  logic [L2_AWIDTH_NOAL-1:0]  cfg_start_addr_i,
  input  logic [L2_AWIDTH_NOAL-1:0]  cfg_size_i,
  udma_stream_sink_if.slave          in_stream,
  output logic                       rx_ch_req_o,
  output logic [L2_AWIDTH_NOAL-1:0]  rx_ch_addr_o,
  output logic [1:0]                 rx_ch_datasize_o,
  output logic [DATA_WIDTH-1:0]      rx_ch_data_o,
  input  logic                       rx_ch_gnt_i,
  output logic                       wr_evt_o,
  output logic [L2_AWIDTH_NOAL-1:0]  wr_evt_addr_o,
  output logic [STREAM_ID_WIDTH-1:0] wr_evt_dest_o,
  output logic [1:0]                 wr_evt_datasize_o,
  output logic                       done_o,
  output logic [L2_AWIDTH_NOAL-1:0]  bytes_o
);

  localparam int AW      = L2_AWIDTH_NOAL;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                     state_r;
  state_e                     state_next_s;
  logic [ENTRY_W-1:0]         fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_idx_r;
  logic [PTR_W-1:0]           rd_idx_r;
  logic [CNT_W-1:0]           count_r;
  logic [AW-1:0]              wr_ptr_r;
  logic [AW-1:0]              bytes_r;
  logic                       evt_r;
  logic [AW-1:0]              evt_addr_r;
  logic [1:0]                 evt_size_r;
  logic [STREAM_ID_WIDTH-1:0] evt_dest_r;
  logic                       done_r;

  logic                       fifo_empty_s;
  logic                       fifo_full_s;
  logic                       dest_match_s;
  logic                       ready_s;
  logic                       push_s;
  logic                       pop_s;
  logic                       req_s;
  logic                       done_set_s;
  logic                       load_ptr_s;
  logic [DATA_WIDTH-1:0]      head_data_s;
  logic [1:0]                 head_size_s;
  logic                       head_sot_s;
  logic [AW-1:0]              wr_addr_s;
  logic [AW-1:0]              inc_s;
  logic [AW-1:0]              next_addr_s;
  logic [AW-1:0]              buf_end_s;
  logic [AW-1:0]              wr_ptr_next_s;

  function automatic logic [AW-1:0] size_to_inc(input logic [1:0] size);
    case (size)
      2'b00:   return AW'(1);
      2'b01:   return AW'(2);
      default: return AW'(4);
    endcase
  endfunction

  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign fifo_full_s  = (count_r == CNT_W'(FIFO_DEPTH));
  assign dest_match_s = (in_stream.dest == STREAM_ID_WIDTH'(INST_ID));
  assign {head_data_s, head_size_s, head_sot_s} = fifo_mem_r[rd_idx_r];

  assign req_s  = !fifo_empty_s && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
  assign pop_s  = req_s && rx_ch_gnt_i;
  assign push_s = ready_s && in_stream.valid;

  // A sot beat restarts the buffer; writes never split across the wrap point.
  assign wr_addr_s     = head_sot_s ? cfg_start_addr_i : wr_ptr_r;
  assign inc_s         = size_to_inc(head_size_s);
  assign next_addr_s   = wr_addr_s + inc_s;
  assign buf_end_s     = cfg_start_addr_i + cfg_size_i;
  assign wr_ptr_next_s = (next_addr_s >= buf_end_s) ? cfg_start_addr_i : next_addr_s;

  assign in_stream.ready   = ready_s;
  assign rx_ch_req_o       = req_s;
  assign rx_ch_addr_o      = req_s ? wr_addr_s   : {AW{1'b0}};
  assign rx_ch_datasize_o  = req_s ? head_size_s : 2'b00;
  assign rx_ch_data_o      = req_s ? head_data_s : {DATA_WIDTH{1'b0}};
  assign wr_evt_o          = evt_r;
  assign wr_evt_addr_o     = evt_addr_r;
  assign wr_evt_dest_o     = evt_dest_r;
  assign wr_evt_datasize_o = evt_size_r;
  assign done_o            = done_r;
  assign bytes_o           = bytes_r;

  // Next-state and per-state strobes of the transfer FSM.
  always_comb begin
    state_next_s = state_r;
    ready_s      = 1'b0;
    done_set_s   = 1'b0;
    load_ptr_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_en_i) begin
          state_next_s = ST_RUN;
          load_ptr_s   = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        ready_s = dest_match_s && !fifo_full_s;
        if ((ready_s && in_stream.valid && in_stream.eot) || !cfg_en_i) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s || ((count_r == CNT_W'(1)) && pop_s)) begin
          state_next_s = ST_IDLE;
          done_set_s   = 1'b1;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i || cfg_clr_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FIFO read/write indices and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i || cfg_clr_i) begin
      wr_idx_r <= {PTR_W{1'b0}};
      rd_idx_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_idx_r <= wr_idx_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_idx_r <= rd_idx_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful below count_r.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_r[wr_idx_r] <= {in_stream.data, in_stream.datasize, in_stream.sot};
    end
  end

  // Circular write pointer and byte counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      bytes_r  <= {AW{1'b0}};
    end else if (cfg_clr_i || load_ptr_s) begin
      wr_ptr_r <= cfg_start_addr_i;
      bytes_r  <= {AW{1'b0}};
    end else if (pop_s) begin
      wr_ptr_r <= wr_ptr_next_s;
      bytes_r  <= bytes_r + inc_s;
    end
  end

  // Write-event and done pulses, plus the held descriptor of the last write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_r      <= 1'b0;
      evt_addr_r <= {AW{1'b0}};
      evt_size_r <= 2'b00;
      evt_dest_r <= {STREAM_ID_WIDTH{1'b0}};
      done_r     <= 1'b0;
    end else if (cfg_clr_i) begin
      evt_r  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      evt_r  <= pop_s;
      done_r <= done_set_s;
      if (pop_s) begin
        evt_addr_r <= wr_addr_s;
        evt_size_r <= head_size_s;
        evt_dest_r <= STREAM_ID_WIDTH'(INST_ID);
      end
    end
  end

endmodule

// File: tb/tb_udma_stream_sink.sv
// Directed bench for udma_stream_sink: each task drives one scenario and
// compares observed writes, events and counters against hand-computed values.
module tb_udma_stream_sink;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam logic [1:0] MY_ID = 2'd1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cfg_en_i;
  logic          cfg_clr_i;
  logic [AW-1:0] cfg_start_addr_i;
  logic [AW-1:0] cfg_size_i;
  logic          rx_ch_req_o;
  logic [AW-1:0] rx_ch_addr_o;
  logic [1:0]    rx_ch_datasize_o;
  logic [DW-1:0] rx_ch_data_o;
  logic          rx_ch_gnt_i;
  logic          wr_evt_o;
  logic [AW-1:0] wr_evt_addr_o;
  logic [SW-1:0] wr_evt_dest_o;
  logic [1:0]    wr_evt_datasize_o;
  logic          done_o;
  logic [AW-1:0] bytes_o;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] evt_addr_q [$];
  logic [1:0]    evt_size_q [$];
  logic [DW-1:0] gnt_data_q [$];

  udma_stream_sink_if #(.DATA_WIDTH(DW), .STREAM_ID_WIDTH(SW)) in_if ();

  udma_stream_sink #(
    .L2_AWIDTH_NOAL (AW),
    .DATA_WIDTH     (DW),
    .STREAM_ID_WIDTH(SW),
    .INST_ID        (1),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_clr_i        (cfg_clr_i),
    .cfg_start_addr_i (cfg_start_addr_i),
    .cfg_size_i       (cfg_size_i),
    .in_stream        (in_if),
    .rx_ch_req_o      (rx_ch_req_o),
    .rx_ch_addr_o     (rx_ch_addr_o),
    .rx_ch_datasize_o (rx_ch_datasize_o),
    .rx_ch_data_o     (rx_ch_data_o),
    .rx_ch_gnt_i      (rx_ch_gnt_i),
    .wr_evt_o         (wr_evt_o),
    .wr_evt_addr_o    (wr_evt_addr_o),
    .wr_evt_dest_o    (wr_evt_dest_o),
    .wr_evt_datasize_o(wr_evt_datasize_o),
    .done_o           (done_o),
    .bytes_o          (bytes_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every write event and every granted data word.
  always @(negedge clk_i) begin
    if (wr_evt_o === 1'b1) begin
      evt_addr_q.push_back(wr_evt_addr_o);
      evt_size_q.push_back(wr_evt_datasize_o);
    end
    if (rx_ch_req_o === 1'b1 && rx_ch_gnt_i === 1'b1) begin
      gnt_data_q.push_back(rx_ch_data_o);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_dut();
    cfg_clr_i = 1'b1; cfg_en_i = 1'b0; rx_ch_gnt_i = 1'b0; in_if.valid = 1'b0;
    cyc();
    cfg_clr_i = 1'b0;
    evt_addr_q.delete(); evt_size_q.delete(); gnt_data_q.delete();
  endtask

  task automatic start_run(input logic [AW-1:0] s, input logic [AW-1:0] z, input logic g);
    clear_dut();
    cfg_start_addr_i = s; cfg_size_i = z; rx_ch_gnt_i = g; cfg_en_i = 1'b1;
    cyc();
  endtask

  task automatic send_beat(input logic [1:0] sz, input logic sot, input logic eot,
                           input logic [DW-1:0] d, output logic req_seen);
    logic acc;
    acc = 1'b0; req_seen = 1'b0;
    in_if.dest = MY_ID; in_if.data = d; in_if.datasize = sz;
    in_if.sot = sot; in_if.eot = eot; in_if.valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk_i);
      acc = in_if.ready;
      req_seen = rx_ch_req_o;
      cyc();
    end
    in_if.valid = 1'b0; in_if.sot = 1'b0; in_if.eot = 1'b0;
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++;
      $display("FAIL beat_accept: ready %b, required 1 within 20 cycles", acc);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cfg_en_i = 1'b0; cfg_clr_i = 1'b0; rx_ch_gnt_i = 1'b1;
    cfg_start_addr_i = 16'h0100; cfg_size_i = 16'h0040;
    in_if.dest = MY_ID; in_if.data = 32'hDEADBEEF; in_if.datasize = 2'b10;
    in_if.valid = 1'b1; in_if.sot = 1'b0; in_if.eot = 1'b0;
    cyc(); cyc();
    @(negedge clk_i);
    vectors++;
    if ({rx_ch_req_o, rx_ch_addr_o, rx_ch_datasize_o, rx_ch_data_o, wr_evt_o, wr_evt_addr_o,
         wr_evt_dest_o, wr_evt_datasize_o, done_o, bytes_o, in_if.ready} !== 94'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: req %b addr %h data %h evt %b bytes %h ready %b, required all 0",
               rx_ch_req_o, rx_ch_addr_o, rx_ch_data_o, wr_evt_o, bytes_o, in_if.ready);
    end
    cyc();
    rst_i = 1'b0; in_if.valid = 1'b0;
  endtask

  task automatic test_basic();
    logic r0, r;
    logic [AW-1:0] exp_a [3];
    logic [AW-1:0] got;
    exp_a = '{16'h0100, 16'h0104, 16'h0108};
    start_run(16'h0100, 16'h0040, 1'b1);
    send_beat(2'b10, 1'b0, 1'b0, 32'h11111111, r0);
    send_beat(2'b10, 1'b0, 1'b0, 32'h22222222, r);
    send_beat(2'b10, 1'b0, 1'b0, 32'h33333333, r);
    repeat (6) cyc();
    vectors++;
    if (r0 !== 1'b0) begin
      miscompares++; $display("FAIL basic_no_bypass: req %b in accept cycle, required 0", r0);
    end
    vectors++;
    if (evt_addr_q.size() != 3) begin
      miscompares++; $display("FAIL basic_evt_count: %0d events, required 3", evt_addr_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < evt_addr_q.size()) ? evt_addr_q[i] : 16'hxxxx;
      vectors++;
      if (got !== exp_a[i]) begin
        miscompares++; $display("FAIL basic_addr[%0d]: %h, required %h", i, got, exp_a[i]);
      end
    end
    vectors++;
    if (bytes_o !== 16'h000C) begin
      miscompares++; $display("FAIL basic_bytes: %h, required 000c", bytes_o);
    end
    vectors++;
    if (wr_evt_dest_o !== MY_ID) begin
      miscompares++; $display("FAIL basic_evt_dest: %h, required %h", wr_evt_dest_o, MY_ID);
    end
  endtask

  task automatic test_wrap();
    logic r;
    logic [AW-1:0] exp_a [4];
    logic [AW-1:0] got;
    exp_a = '{16'h0100, 16'h0104, 16'h0100, 16'h0104};
    start_run(16'h0100, 16'h0008, 1'b1);
    for (int i = 0; i < 4; i++) send_beat(2'b10, 1'b0, 1'b0, 32'hA0 + i, r);
    repeat (6) cyc();
    for (int i = 0; i < 4; i++) begin
      got = (i < evt_addr_q.size()) ? evt_addr_q[i] : 16'hxxxx;
      vectors++;
      if (got !== exp_a[i]) begin
        miscompares++; $display("FAIL wrap_addr[%0d]: %h, required %h", i, got, exp_a[i]);
      end
    end
    vectors++;
    if (bytes_o !== 16'h0010) begin
      miscompares++; $display("FAIL wrap_bytes: %h, required 0010", bytes_o);
    end
  endtask

  task automatic test_mixed_sot();
    logic r;
    logic [AW-1:0] exp_a [4];
    logic [1:0]    exp_s [4];
    logic [AW-1:0] got;
    logic [1:0]    gs;
    exp_a = '{16'h0100, 16'h0101, 16'h0103, 16'h0100};
    exp_s = '{2'b00, 2'b01, 2'b10, 2'b10};
    start_run(16'h0100, 16'h0040, 1'b1);
    send_beat(2'b00, 1'b0, 1'b0, 32'h000000AA, r);
    send_beat(2'b01, 1'b0, 1'b0, 32'h0000BBBB, r);
    send_beat(2'b10, 1'b0, 1'b0, 32'hCCCCCCCC, r);
    send_beat(2'b10, 1'b1, 1'b0, 32'hDDDDDDDD, r);
    repeat (6) cyc();
    for (int i = 0; i < 4; i++) begin
      got = (i < evt_addr_q.size()) ? evt_addr_q[i] : 16'hxxxx;
      gs  = (i < evt_size_q.size()) ? evt_size_q[i] : 2'bxx;
      vectors++;
      if (got !== exp_a[i] || gs !== exp_s[i]) begin
        miscompares++;
        $display("FAIL mixed_evt[%0d]: addr %h size %b, required addr %h size %b",
                 i, got, gs, exp_a[i], exp_s[i]);
      end
    end
    vectors++;
    if (bytes_o !== 16'h000B) begin
      miscompares++; $display("FAIL mixed_bytes: %h, required 000b", bytes_o);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    logic acc, unstable;
    logic [AW-1:0] exp_a [4];
    logic [AW-1:0] got;
    logic [DW-1:0] gd;
    exp_a = '{16'h0200, 16'h0204, 16'h0208, 16'h020C};
    start_run(16'h0200, 16'h0040, 1'b0);
    idx = 0; unstable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_if.dest = MY_ID; in_if.datasize = 2'b10; in_if.sot = 1'b0; in_if.eot = 1'b0;
      in_if.data = 32'hA0 + idx; in_if.valid = (idx < 6);
      @(negedge clk_i);
      acc = in_if.valid && in_if.ready;
      if (c >= 1 && (rx_ch_req_o !== 1'b1 || rx_ch_addr_o !== 16'h0200 || rx_ch_data_o !== 32'hA0))
        unstable = 1'b1;
      cyc();
      if (acc) idx++;
    end
    vectors++;
    if (idx != 4) begin
      miscompares++; $display("FAIL bp_accepted: %0d beats, required 4", idx);
    end
    vectors++;
    if (unstable !== 1'b0) begin
      miscompares++; $display("FAIL bp_req_stable: unstable %b, required 0", unstable);
    end
    rx_ch_gnt_i = 1'b1; in_if.valid = 1'b1; in_if.data = 32'hA4;
    @(negedge clk_i);
    vectors++;
    if (in_if.ready !== 1'b0 || rx_ch_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full_pop_ready: ready %b req %b, required ready 0 req 1", in_if.ready, rx_ch_req_o);
    end
    cyc();
    in_if.valid = 1'b0;
    repeat (8) cyc();
    for (int i = 0; i < 4; i++) begin
      got = (i < evt_addr_q.size()) ? evt_addr_q[i] : 16'hxxxx;
      gd  = (i < gnt_data_q.size()) ? gnt_data_q[i] : 32'hxxxxxxxx;
      vectors++;
      if (got !== exp_a[i] || gd !== 32'hA0 + i) begin
        miscompares++;
        $display("FAIL bp_drain[%0d]: addr %h data %h, required addr %h data %h",
                 i, got, gd, exp_a[i], 32'hA0 + i);
      end
    end
    vectors++;
    if (gnt_data_q.size() != 4) begin
      miscompares++; $display("FAIL bp_write_count: %0d, required 4", gnt_data_q.size());
    end
  endtask

  task automatic test_eot_done();
    logic r;
    int done_cnt;
    logic evt_at_done, ready_at_done;
    logic [AW-1:0] addr_at_done;
    start_run(16'h0100, 16'h0040, 1'b1);
    send_beat(2'b10, 1'b0, 1'b0, 32'h1, r);
    send_beat(2'b10, 1'b0, 1'b0, 32'h2, r);
    send_beat(2'b10, 1'b0, 1'b1, 32'h3, r);
    in_if.valid = 1'b1; in_if.dest = MY_ID;
    @(negedge clk_i);
    vectors++;
    if (in_if.ready !== 1'b0) begin
      miscompares++; $display("FAIL eot_ready_drop: %b, required 0", in_if.ready);
    end
    cyc();
    in_if.valid = 1'b0;
    done_cnt = 0; evt_at_done = 1'b0; ready_at_done = 1'bx; addr_at_done = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        done_cnt++;
        evt_at_done = wr_evt_o; ready_at_done = in_if.ready; addr_at_done = wr_evt_addr_o;
      end
      cyc();
    end
    cfg_en_i = 1'b0;
    vectors++;
    if (done_cnt != 1) begin
      miscompares++; $display("FAIL eot_done_count: %0d pulses, required 1", done_cnt);
    end
    vectors++;
    if (evt_at_done !== 1'b1 || addr_at_done !== 16'h0108) begin
      miscompares++;
      $display("FAIL eot_done_timing: evt %b addr %h at done, required evt 1 addr 0108",
               evt_at_done, addr_at_done);
    end
    vectors++;
    if (ready_at_done !== 1'b0) begin
      miscompares++; $display("FAIL eot_idle_ready: %b at done, required 0", ready_at_done);
    end
  endtask

  task automatic test_clear();
    logic r;
    start_run(16'h0100, 16'h0040, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(2'b10, 1'b0, 1'b0, 32'h50 + i, r);
    rx_ch_gnt_i = 1'b1;
    cyc();
    cfg_clr_i = 1'b1; cfg_en_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (wr_evt_o !== 1'b1 || bytes_o !== 16'h0004 || rx_ch_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_pre: evt %b bytes %h req %b, required evt 1 bytes 0004 req 1",
               wr_evt_o, bytes_o, rx_ch_req_o);
    end
    cyc();
    cfg_clr_i = 1'b0; rx_ch_gnt_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (wr_evt_o !== 1'b0 || rx_ch_req_o !== 1'b0 || bytes_o !== 16'h0000) begin
      miscompares++;
      $display("FAIL clr_post: evt %b req %b bytes %h, required 0 0 0000", wr_evt_o, rx_ch_req_o, bytes_o);
    end
    cyc();
  endtask

  task automatic test_reset_midrun();
    logic r;
    start_run(16'h0100, 16'h0040, 1'b1);
    send_beat(2'b10, 1'b0, 1'b0, 32'h61, r);
    send_beat(2'b10, 1'b0, 1'b0, 32'h62, r);
    repeat (2) cyc();
    rx_ch_gnt_i = 1'b0;
    send_beat(2'b10, 1'b0, 1'b0, 32'h63, r);
    send_beat(2'b10, 1'b0, 1'b0, 32'h64, r);
    @(negedge clk_i);
    vectors++;
    if (bytes_o !== 16'h0008 || rx_ch_req_o !== 1'b1 || wr_evt_addr_o !== 16'h0104) begin
      miscompares++;
      $display("FAIL rst_pre: bytes %h req %b evt_addr %h, required 0008 1 0104",
               bytes_o, rx_ch_req_o, wr_evt_addr_o);
    end
    cyc();
    rst_i = 1'b1; in_if.valid = 1'b1; in_if.dest = MY_ID;
    cyc();
    @(negedge clk_i);
    vectors++;
    if ({rx_ch_req_o, rx_ch_addr_o, rx_ch_datasize_o, rx_ch_data_o, wr_evt_o, wr_evt_addr_o,
         wr_evt_dest_o, wr_evt_datasize_o, done_o, bytes_o, in_if.ready} !== 94'd0) begin
      miscompares++;
      $display("FAIL rst_midrun: req %b addr %h evt %b evt_addr %h bytes %h ready %b, required all 0",
               rx_ch_req_o, rx_ch_addr_o, wr_evt_o, wr_evt_addr_o, bytes_o, in_if.ready);
    end
    cyc();
    rst_i = 1'b0; in_if.valid = 1'b0; cfg_en_i = 1'b0;
    cyc();
  endtask

  task automatic test_wrong_dest();
    int ready_seen;
    start_run(16'h0100, 16'h0040, 1'b1);
    ready_seen = 0;
    in_if.valid = 1'b1; in_if.datasize = 2'b10; in_if.data = 32'h77;
    in_if.sot = 1'b0; in_if.eot = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_if.dest = (c < 3) ? 2'd0 : 2'd2;
      @(negedge clk_i);
      if (in_if.ready !== 1'b0) ready_seen++;
      cyc();
    end
    in_if.valid = 1'b0;
    repeat (3) cyc();
    vectors++;
    if (ready_seen != 0) begin
      miscompares++; $display("FAIL wdest_ready: high %0d cycles, required 0", ready_seen);
    end
    vectors++;
    if (gnt_data_q.size() != 0 || bytes_o !== 16'h0000) begin
      miscompares++;
      $display("FAIL wdest_writes: %0d writes bytes %h, required 0 0000", gnt_data_q.size(), bytes_o);
    end
    in_if.dest = MY_ID;
    @(negedge clk_i);
    vectors++;
    if (in_if.ready !== 1'b1) begin
      miscompares++; $display("FAIL wdest_own_ready: %b, required 1", in_if.ready);
    end
    cyc();
    cfg_en_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_mixed_sot();
    test_backpressure();
    test_eot_done();
    test_clear();
    test_reset_midrun();
    test_wrong_dest();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
